// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: widths, halt opcode, fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INSTR_W = 16;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef logic [ADDR_W-1:0]  pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer between IMem read data and decode, with the output mux
// that prefers the held word over the word currently on the IMem bus.
module fetch_skid #(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_infl_valid,
    input  logic [ADDR_W-1:0]  i_infl_pc,
    input  logic [INSTR_W-1:0] i_imem_q,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    output logic               o_take
);
    import cpu_pkg::*;

    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0]  r_skid_pc;

    always_comb begin
        o_instr_valid = (r_skid_valid | i_infl_valid) & ~i_flush;
        o_instr       = r_skid_valid ? r_skid_instr : i_imem_q;
        o_instr_pc    = r_skid_valid ? r_skid_pc    : i_infl_pc;
        o_take        = o_instr_valid & ~i_stall;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_skid_valid <= 1'b0;
        end else if (i_stall && i_infl_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= i_imem_q;
            r_skid_pc    <= i_infl_pc;
        end else if (o_take) begin
            r_skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC and IMem address, tracks the word
// in flight, applies redirects and stops after a delivered HALT instruction.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [15:0]        fetch_count
);
    import cpu_pkg::*;

    fetch_state_t       r_state;
    fetch_state_t       w_state_d;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_infl_valid;
    logic [ADDR_W-1:0]  r_infl_pc;
    logic [15:0]        r_count;

    logic               w_take;
    logic               w_halt_take;
    logic               w_issue;

    fetch_skid #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .i_clk         (clock),
        .i_rst_n       (reset_n),
        .i_stall       (stall),
        .i_flush       (redirect_valid),
        .i_infl_valid  (r_infl_valid),
        .i_infl_pc     (r_infl_pc),
        .i_imem_q      (imem_q),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_take        (w_take)
    );

    // The HALT edge must not advance the PC, so a later restart resumes at HALT + 1.
    assign w_halt_take = w_take && (r_state == RUN) && (instr[INSTR_W-1 -: 4] == HALT_OP);
    assign w_issue     = (r_state == RUN) && !stall && !redirect_valid && !w_halt_take;

    always_comb begin
        w_state_d = r_state;
        if (!redirect_valid) begin
            unique case (r_state)
                IDLE:    if (start) w_state_d = RUN;
                RUN:     if (w_halt_take) w_state_d = HALT;
                HALT:    if (start) w_state_d = RUN;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_infl_valid <= 1'b0;
            r_infl_pc    <= '0;
        end else begin
            r_state <= w_state_d;
            if (redirect_valid) begin
                r_pc         <= redirect_pc;
                r_infl_valid <= 1'b0;
            end else if (w_issue) begin
                r_infl_pc    <= r_pc;
                r_pc         <= r_pc + ADDR_W'(1);
                r_infl_valid <= 1'b1;
            end else begin
                r_infl_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_take && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus hand-written
// sequences for free run/HALT/restart, address wrap and mid-stall reset.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [15:0] imem_q;
    logic        instr_valid;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic [15:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [11:0] rpc;
        logic        vld;
        logic [15:0] ins;
        logic [11:0] pc;
        logic [11:0] addr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[21];

    fetch_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_f(input logic [11:0] a);
        if (a == 12'h008) return 16'hF000;
        return {4'h1, a};
    endfunction

    always @(posedge clock) imem_q <= mem_f(imem_addr);

    function automatic vec_t mk(input logic s, input logic r, input logic [11:0] rp,
                                input logic v, input logic [15:0] ins, input logic [11:0] pc,
                                input logic [11:0] addr, input logic [15:0] cnt);
        vec_t t;
        t.stall = s;  t.redir = r;  t.rpc  = rp;  t.vld = v;
        t.ins   = ins; t.pc   = pc; t.addr = addr; t.cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] ins,
                             input logic [11:0] pc, input logic [11:0] addr,
                             input logic [15:0] cnt);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        if (v) begin
            check({tag, ".instr"}, {16'd0, instr}, {16'd0, ins});
            check({tag, ".pc"}, {20'd0, instr_pc}, {20'd0, pc});
        end
        check({tag, ".addr"}, {20'd0, imem_addr}, {20'd0, addr});
        check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
    endtask

    // Inputs change 2 time units after the edge, outputs are sampled 2 units later.
    task automatic step(input logic s, input logic r, input logic [11:0] rp, input logic st);
        @(posedge clock);
        #2;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        start          = st;
        #2;
    endtask

    task automatic do_reset(input string tag);
        reset_n        = 1'b0;
        start          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        #1;
        check_out({tag, ".rst"}, 1'b0, 16'h0, 12'h0, 12'h000, 16'd0);
        check({tag, ".rst.instr_pc"}, {20'd0, instr_pc}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h000, 16'd0);
        vecs[1]  = mk(0, 0, 12'h000, 1, 16'h1000, 12'h000, 12'h001, 16'd0);
        vecs[2]  = mk(0, 1, 12'h005, 0, 16'h0000, 12'h000, 12'h002, 16'd1);
        vecs[3]  = mk(0, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h005, 16'd1);
        vecs[4]  = mk(0, 0, 12'h000, 1, 16'h1005, 12'h005, 12'h006, 16'd1);
        vecs[5]  = mk(0, 0, 12'h000, 1, 16'h1006, 12'h006, 12'h007, 16'd2);
        vecs[6]  = mk(0, 0, 12'h000, 1, 16'h1007, 12'h007, 12'h008, 16'd3);
        vecs[7]  = mk(0, 1, 12'h002, 0, 16'h0000, 12'h000, 12'h009, 16'd4);
        vecs[8]  = mk(0, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h002, 16'd4);
        vecs[9]  = mk(1, 0, 12'h000, 1, 16'h1002, 12'h002, 12'h003, 16'd4);
        vecs[10] = mk(1, 0, 12'h000, 1, 16'h1002, 12'h002, 12'h003, 16'd4);
        vecs[11] = mk(1, 0, 12'h000, 1, 16'h1002, 12'h002, 12'h003, 16'd4);
        vecs[12] = mk(0, 0, 12'h000, 1, 16'h1002, 12'h002, 12'h003, 16'd4);
        vecs[13] = mk(0, 0, 12'h000, 1, 16'h1003, 12'h003, 12'h004, 16'd5);
        vecs[14] = mk(0, 0, 12'h000, 1, 16'h1004, 12'h004, 12'h005, 16'd6);
        vecs[15] = mk(1, 0, 12'h000, 1, 16'h1005, 12'h005, 12'h006, 16'd7);
        vecs[16] = mk(1, 1, 12'h00A, 0, 16'h0000, 12'h000, 12'h006, 16'd7);
        vecs[17] = mk(1, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h00A, 16'd7);
        vecs[18] = mk(0, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h00A, 16'd7);
        vecs[19] = mk(0, 0, 12'h000, 1, 16'h100A, 12'h00A, 12'h00B, 16'd7);
        vecs[20] = mk(0, 0, 12'h000, 1, 16'h100B, 12'h00B, 12'h00C, 16'd8);

        // Free run to HALT, then restart from HALT + 1.
        do_reset("run");
        step(0, 0, 12'h000, 1);
        step(0, 0, 12'h000, 0);
        check_out("run.c1", 1'b0, 16'h0, 12'h0, 12'h000, 16'd0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 12'h000, 0);
            check_out($sformatf("run.i%0d", i), 1'b1, mem_f(12'(i)), 12'(i),
                      12'(i + 1), 16'(i));
        end
        step(0, 0, 12'h000, 0);
        check_out("run.halt1", 1'b0, 16'h0, 12'h0, 12'h009, 16'd9);
        step(0, 0, 12'h000, 1);
        check_out("run.halt2", 1'b0, 16'h0, 12'h0, 12'h009, 16'd9);
        step(0, 0, 12'h000, 0);
        check_out("run.restart", 1'b0, 16'h0, 12'h0, 12'h009, 16'd9);
        step(0, 0, 12'h000, 0);
        check_out("run.resume", 1'b1, 16'h1009, 12'h009, 12'h00A, 16'd9);

        // Redirect, redirect over a valid HALT, stall/skid, redirect+stall flush.
        do_reset("vec");
        step(0, 0, 12'h000, 1);
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].stall, vecs[i].redir, vecs[i].rpc, 0);
            check_out($sformatf("vec.c%0d", i + 1), vecs[i].vld, vecs[i].ins, vecs[i].pc,
                      vecs[i].addr, vecs[i].cnt);
        end

        // PC wrap through 12'hFFF.
        do_reset("wrap");
        step(0, 0, 12'h000, 1);
        step(0, 0, 12'h000, 0);
        check_out("wrap.c1", 1'b0, 16'h0, 12'h0, 12'h000, 16'd0);
        step(0, 1, 12'hFFE, 0);
        check_out("wrap.redir", 1'b0, 16'h0, 12'h0, 12'h001, 16'd0);
        step(0, 0, 12'h000, 0);
        check_out("wrap.bubble", 1'b0, 16'h0, 12'h0, 12'hFFE, 16'd0);
        step(0, 0, 12'h000, 0);
        check_out("wrap.ffe", 1'b1, 16'h1FFE, 12'hFFE, 12'hFFF, 16'd0);
        step(0, 0, 12'h000, 0);
        check_out("wrap.fff", 1'b1, 16'h1FFF, 12'hFFF, 12'h000, 16'd1);
        step(0, 0, 12'h000, 0);
        check_out("wrap.000", 1'b1, 16'h1000, 12'h000, 12'h001, 16'd2);

        // Asynchronous reset while the skid buffer holds a stalled word.
        do_reset("mid");
        step(0, 0, 12'h000, 1);
        step(0, 0, 12'h000, 0);
        step(0, 0, 12'h000, 0);
        step(0, 0, 12'h000, 0);
        step(1, 0, 12'h000, 0);
        step(1, 0, 12'h000, 0);
        check_out("mid.held", 1'b1, 16'h1002, 12'h002, 12'h003, 16'd2);
        #1;
        reset_n = 1'b0;
        #1;
        check_out("mid.async", 1'b0, 16'h0, 12'h0, 12'h000, 16'd0);
        check("mid.async.instr_pc", {20'd0, instr_pc}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 12'h000, 0);
            check_out($sformatf("mid.idle%0d", i), 1'b0, 16'h0, 12'h0, 12'h000, 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
